cache_nway_wb: RTL and testbench

//  Parametrised N-way set-associative write-back, write-allocate cache between one CPU port and a word-wide memory port.

---
 rtl/cache_nway_wb.sv | 198 +++++++++++++++++++
 tb/tb_cache_nway_wb.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_nway_wb.sv
// rtl/cache_nway_wb.sv - N-way set-associative write-back, write-allocate cache with true-LRU ageing
module cache_nway_wb #(
   parameter int ADR_WIDTH      = 32,
   parameter int WORD_WIDTH     = 32,
   parameter int WAY_NUM        = 4,
   parameter int SETS           = 128,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cpu_req_i,
   input  logic                  cpu_rdwr_i,
   input  logic [ADR_WIDTH-1:0]  cpu_adr_i,
   input  logic [WORD_WIDTH-1:0] cpu_dat_i,
   output logic                  cpu_ack_o,
   output logic [WORD_WIDTH-1:0] cpu_dat_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADR_WIDTH-1:0]  mem_adr_o,
   output logic [WORD_WIDTH-1:0] mem_dat_o,
   input  logic                  mem_ack_i,
   input  logic [WORD_WIDTH-1:0] mem_dat_i,
   output logic [31:0]           hit_cnt_o,
   output logic [31:0]           miss_cnt_o
);
   localparam int BOFF = $clog2(WORD_WIDTH / 8);
   localparam int WOFF = $clog2(WORDS_PER_LINE);
   localparam int IDXW = $clog2(SETS);
   localparam int WAYW = $clog2(WAY_NUM);
   localparam int TAGW = ADR_WIDTH - BOFF - WOFF - IDXW;
   localparam logic [WAYW-1:0] OLDEST = WAYW'(WAY_NUM - 1);

   typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;
   state_t state, state_nx;

   logic [TAGW-1:0]       req_tag;
   logic [IDXW-1:0]       req_idx;
   logic [WOFF-1:0]       req_word;
   logic                  req_we;
   logic [WORD_WIDTH-1:0] req_dat;

   logic [TAGW-1:0]       tag_mem  [WAY_NUM][SETS];
   logic [WORD_WIDTH-1:0] data_mem [WAY_NUM][SETS][WORDS_PER_LINE];
   logic                  valid    [WAY_NUM][SETS];
   logic                  dirty    [WAY_NUM][SETS];
   logic [WAYW-1:0]       age      [WAY_NUM][SETS];

   logic [WAYW-1:0] way, hit_way, vic_way;
   logic            hit, found_inv, vic_dirty;
   logic [WOFF-1:0] word_cnt;
   logic            last_word;
   logic            unused_adr;

   assign unused_adr = ^cpu_adr_i;
   assign last_word  = &word_cnt;
   assign vic_dirty  = valid[vic_way][req_idx] && dirty[vic_way][req_idx];

   function automatic logic [ADR_WIDTH-1:0] word_adr(input logic [TAGW-1:0] t,
                                                    input logic [IDXW-1:0] i,
                                                    input logic [WOFF-1:0] w);
      return ADR_WIDTH'({t, i, w}) << BOFF;
   endfunction

   // Victim preference: lowest invalid way, otherwise the oldest one.
   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      vic_way   = '0;
      found_inv = 1'b0;
      for (int w = WAY_NUM - 1; w >= 0; w--) begin
         if (!valid[w][req_idx]) begin
            vic_way   = WAYW'(w);
            found_inv = 1'b1;
         end
      end
      if (!found_inv) begin
         for (int w = 0; w < WAY_NUM; w++) begin
            if (age[w][req_idx] == OLDEST) vic_way = WAYW'(w);
         end
      end
      for (int w = 0; w < WAY_NUM; w++) begin
         if (valid[w][req_idx] && tag_mem[w][req_idx] == req_tag) begin
            hit     = 1'b1;
            hit_way = WAYW'(w);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      cpu_ack_o = 1'b0;
      cpu_dat_o = '0;
      mem_req_o = 1'b0;
      mem_we_o  = 1'b0;
      mem_adr_o = '0;
      mem_dat_o = '0;
      case (state)
         IDLE:      if (cpu_req_i) state_nx = LOOKUP;
         LOOKUP: begin
            if (hit)            state_nx = RESPOND;
            else if (vic_dirty) state_nx = WRITEBACK;
            else                state_nx = REFILL;
         end
         WRITEBACK: begin
            mem_req_o = 1'b1;
            mem_we_o  = 1'b1;
            mem_adr_o = word_adr(tag_mem[way][req_idx], req_idx, word_cnt);
            mem_dat_o = data_mem[way][req_idx][word_cnt];
            if (mem_ack_i && last_word) state_nx = REFILL;
         end
         REFILL: begin
            mem_req_o = 1'b1;
            mem_adr_o = word_adr(req_tag, req_idx, word_cnt);
            if (mem_ack_i && last_word) state_nx = RESPOND;
         end
         RESPOND: begin
            cpu_ack_o = 1'b1;
            if (!req_we) cpu_dat_o = data_mem[way][req_idx][req_word];
            state_nx = IDLE;
         end
         default:   state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_tag    <= '0;
         req_idx    <= '0;
         req_word   <= '0;
         req_we     <= 1'b0;
         req_dat    <= '0;
         way        <= '0;
         word_cnt   <= '0;
         hit_cnt_o  <= '0;
         miss_cnt_o <= '0;
         for (int w = 0; w < WAY_NUM; w++) begin
            for (int s = 0; s < SETS; s++) begin
               valid[w][s] <= 1'b0;
               dirty[w][s] <= 1'b0;
               age[w][s]   <= WAYW'(w);
            end
         end
      end else begin
         case (state)
            IDLE: if (cpu_req_i) begin
               req_tag  <= cpu_adr_i[ADR_WIDTH-1 -: TAGW];
               req_idx  <= cpu_adr_i[BOFF+WOFF +: IDXW];
               req_word <= cpu_adr_i[BOFF +: WOFF];
               req_we   <= cpu_rdwr_i;
               req_dat  <= cpu_dat_i;
            end
            LOOKUP: begin
               word_cnt <= '0;
               if (hit) begin
                  way <= hit_way;
                  if (hit_cnt_o != 32'hFFFF_FFFF) hit_cnt_o <= hit_cnt_o + 32'd1;
               end else begin
                  way <= vic_way;
                  if (miss_cnt_o != 32'hFFFF_FFFF) miss_cnt_o <= miss_cnt_o + 32'd1;
                  // The victim line is gone from the moment its writeback starts.
                  if (vic_dirty) valid[vic_way][req_idx] <= 1'b0;
               end
            end
            WRITEBACK: if (mem_ack_i) word_cnt <= word_cnt + 1'b1;
            REFILL: if (mem_ack_i) begin
               word_cnt <= word_cnt + 1'b1;
               if (last_word) begin
                  valid[way][req_idx] <= 1'b1;
                  dirty[way][req_idx] <= 1'b0;
               end
            end
            RESPOND: begin
               if (req_we) dirty[way][req_idx] <= 1'b1;
               for (int w = 0; w < WAY_NUM; w++) begin
                  if (WAYW'(w) == way)
                     age[w][req_idx] <= '0;
                  else if (age[w][req_idx] < age[way][req_idx])
                     age[w][req_idx] <= age[w][req_idx] + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == REFILL && mem_ack_i) begin
         data_mem[way][req_idx][word_cnt] <= mem_dat_i;
         if (last_word) tag_mem[way][req_idx] <= req_tag;
      end
      if (state == RESPOND && req_we) data_mem[way][req_idx][req_word] <= req_dat;
   end
endmodule

// File: tb/tb_cache_nway_wb.sv
// tb/tb_cache_nway_wb.sv - directed self-checking bench for cache_nway_wb
module tb_cache_nway_wb;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_req_i = 1'b0;
   logic        cpu_rdwr_i = 1'b0;
   logic [31:0] cpu_adr_i = '0;
   logic [31:0] cpu_dat_i = '0;
   logic        cpu_ack_o;
   logic [31:0] cpu_dat_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_adr_o;
   logic [31:0] mem_dat_o;
   logic        mem_ack_i;
   logic [31:0] mem_dat_i;
   logic [31:0] hit_cnt_o;
   logic [31:0] miss_cnt_o;

   int total = 0;
   int bad = 0;

   logic [31:0] mem_model [logic [31:0]];
   logic [31:0] log_adr [16];
   logic [31:0] log_dat [16];
   logic        log_we  [16];
   int          log_n = 0;
   int          stall_at = -1;
   int          stall_cnt = 0;
   logic [31:0] stall_adr = '0;

   cache_nway_wb dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req_i(cpu_req_i), .cpu_rdwr_i(cpu_rdwr_i), .cpu_adr_i(cpu_adr_i), .cpu_dat_i(cpu_dat_i),
      .cpu_ack_o(cpu_ack_o), .cpu_dat_o(cpu_dat_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o),
      .mem_ack_i(mem_ack_i), .mem_dat_i(mem_dat_i),
      .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] dflt(input logic [31:0] a);
      if (a[31:4] == 28'h123) return 32'hA0 + 32'(a[3:2]);
      return a | 32'h3;
   endfunction

   // Memory responder: zero-wait acks, optional 10-cycle stall after a given transfer count.
   initial begin
      mem_ack_i = 1'b0;
      mem_dat_i = '0;
      forever begin
         @(negedge clk);
         if (mem_req_o === 1'b1) begin
            if (stall_at >= 0 && log_n == stall_at) begin
               stall_cnt = 10;
               stall_at  = -1;
            end
            if (stall_cnt > 0) begin
               chk("stall_adr", mem_adr_o, stall_adr);
               chk("stall_we", {31'b0, mem_we_o}, 32'd0);
               stall_cnt--;
               mem_ack_i = 1'b0;
            end else begin
               mem_ack_i = 1'b1;
               if (mem_we_o) mem_model[mem_adr_o] = mem_dat_o;
               mem_dat_i = mem_we_o ? 32'h0 :
                           (mem_model.exists(mem_adr_o) ? mem_model[mem_adr_o] : dflt(mem_adr_o));
               if (log_n < 16) begin
                  log_adr[log_n] = mem_adr_o;
                  log_dat[log_n] = mem_dat_o;
                  log_we[log_n]  = mem_we_o;
               end
               log_n++;
            end
         end else begin
            mem_ack_i = 1'b0;
         end
      end
   end

   task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat);
      log_n = 0;
      @(negedge clk);
      cpu_req_i = 1'b1; cpu_rdwr_i = we; cpu_adr_i = adr; cpu_dat_i = dat;
      @(posedge clk);
      #1;
      cpu_req_i = 1'b0; cpu_rdwr_i = ~we; cpu_adr_i = '1; cpu_dat_i = 32'h5A5A_5A5A;
   endtask

   task automatic access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         output logic [31:0] rdata, output int lat);
      bit got = 0;
      issue(we, adr, dat);
      lat = 0;
      rdata = 'x;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         lat++;
         if (cpu_ack_o) begin
            rdata = cpu_dat_o;
            got = 1;
         end
      end
      if (!got) lat = -1;
   endtask

   initial begin
      logic [31:0] rd;
      int lat;
      bit reached;

      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ack", {31'b0, cpu_ack_o}, 32'd0);
      chk("rst_dat", cpu_dat_o, 32'd0);
      chk("rst_mreq", {31'b0, mem_req_o}, 32'd0);
      chk("rst_hit", hit_cnt_o, 32'd0);
      chk("rst_miss", miss_cnt_o, 32'd0);
      rst_n = 1'b1;

      // Cold read miss with refill of the 0x1230 line.
      access(1'b0, 32'h0000_1234, 32'h0, rd, lat);
      chk("cold_dat", rd, 32'hA1);
      chk("cold_lat", lat, 32'd6);
      chk("cold_nxfer", log_n, 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk("cold_adr", log_adr[i], 32'h1230 + 32'(4 * i));
         chk("cold_we", {31'b0, log_we[i]}, 32'd0);
      end
      chk("cold_miss", miss_cnt_o, 32'd1);

      access(1'b0, 32'h0000_1234, 32'h0, rd, lat);
      chk("hit_dat", rd, 32'hA1);
      chk("hit_lat", lat, 32'd2);
      chk("hit_nxfer", log_n, 32'd0);
      chk("hit_cnt1", hit_cnt_o, 32'd1);

      access(1'b1, 32'h0000_1238, 32'hDEAD_BEEF, rd, lat);
      chk("wr_lat", lat, 32'd2);
      chk("wr_dat0", rd, 32'd0);
      access(1'b0, 32'h0000_1238, 32'h0, rd, lat);
      chk("rdback", rd, 32'hDEAD_BEEF);
      chk("hit_cnt3", hit_cnt_o, 32'd3);

      // Fill set 0x23: tag0 (written, dirty), tag1, tag3, then touch the 0x1230 line.
      access(1'b1, 32'h0000_0230, 32'h1234_5678, rd, lat);
      chk("wmiss_lat", lat, 32'd6);
      chk("wmiss_dat0", rd, 32'd0);
      access(1'b0, 32'h0000_0A30, 32'h0, rd, lat);
      chk("t1_dat", rd, 32'h0A33);
      access(1'b0, 32'h0000_1A30, 32'h0, rd, lat);
      chk("t3_dat", rd, 32'h1A33);
      access(1'b0, 32'h0000_1230, 32'h0, rd, lat);
      chk("touch_dat", rd, 32'hA0);
      chk("touch_lat", lat, 32'd2);
      chk("miss_cnt4", miss_cnt_o, 32'd4);

      // Fifth tag evicts the LRU way (dirty tag0 line): writeback then refill.
      access(1'b0, 32'h0000_2230, 32'h0, rd, lat);
      chk("evict_dat", rd, 32'h2233);
      chk("evict_lat", lat, 32'd10);
      chk("evict_nxfer", log_n, 32'd8);
      for (int i = 0; i < 8; i++) begin
         chk("evict_adr", log_adr[i], (i < 4) ? 32'h0230 + 32'(4 * i) : 32'h2230 + 32'(4 * (i - 4)));
         chk("evict_we", {31'b0, log_we[i]}, (i < 4) ? 32'd1 : 32'd0);
         if (i < 4) chk("evict_wdat", log_dat[i], (i == 0) ? 32'h1234_5678 : 32'h0233 + 32'(4 * i));
      end
      access(1'b0, 32'h0000_1234, 32'h0, rd, lat);
      chk("survivor_lat", lat, 32'd2);
      chk("survivor_dat", rd, 32'hA1);

      // Refill stalled for 10 cycles after two words.
      stall_at  = 2;
      stall_adr = 32'h0000_2A38;
      access(1'b0, 32'h0000_2A34, 32'h0, rd, lat);
      chk("stall_lat", lat, 32'd16);
      chk("stall_dat", rd, 32'h2A37);
      chk("stall_nxfer", log_n, 32'd4);

      access(1'b0, 32'h0000_3230, 32'h0, rd, lat);
      chk("t6_lat", lat, 32'd6);
      access(1'b0, 32'h0000_3A30, 32'h0, rd, lat);
      chk("t7_lat", lat, 32'd6);
      chk("miss_cnt8", miss_cnt_o, 32'd8);

      // Tag8 evicts the dirty 0x1230 line; reset lands while word 2 is presented.
      issue(1'b0, 32'h0000_4230, 32'h0);
      reached = 0;
      for (int i = 0; i < 50 && !reached; i++) begin
         @(negedge clk);
         #1;
         if (log_n >= 2) reached = 1;
      end
      chk("wb_reached", {31'b0, reached}, 32'd1);
      @(posedge clk);
      #1;
      chk("wb0_adr", log_adr[0], 32'h1230);
      chk("wb0_dat", log_dat[0], 32'hA0);
      chk("wb1_adr", log_adr[1], 32'h1234);
      chk("wb2_adr", mem_adr_o, 32'h1238);
      chk("wb2_dat", mem_dat_o, 32'hDEAD_BEEF);
      chk("wb2_we", {31'b0, mem_we_o}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_mreq", {31'b0, mem_req_o}, 32'd0);
      chk("arst_mwe", {31'b0, mem_we_o}, 32'd0);
      chk("arst_madr", mem_adr_o, 32'd0);
      chk("arst_mdat", mem_dat_o, 32'd0);
      chk("arst_ack", {31'b0, cpu_ack_o}, 32'd0);
      chk("arst_miss", miss_cnt_o, 32'd0);
      chk("arst_hit", hit_cnt_o, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      access(1'b0, 32'h0000_1234, 32'h0, rd, lat);
      chk("post_lat", lat, 32'd6);
      chk("post_dat", rd, 32'hA1);
      chk("post_miss", miss_cnt_o, 32'd1);
      chk("post_hit", hit_cnt_o, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
